tx_frame_sched: RTL and testbench

Transmit scheduler for the 10G measurement generator. It decides when the XGMII frame generator emits an ARP request or an IPv4 test frame, and enforces the inter-frame gap. It also maintains the per-frame header fields (IPv4 ID, full-route destination index, resolved destination MAC) and publishes per-second TX packet and byte statistics to the PCI user registers.

---
 rtl/tx_frame_sched_if.sv | 25 ++
 rtl/tx_frame_sched.sv | 212 +++++++++++++++++++++
 tb/tb_tx_frame_sched.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_sched_if.sv
// Frame generator handshake: the scheduler requests frames and publishes the
// header fields; the generator reports the end of each frame with gen_done.
interface tx_frame_sched_if;
  logic        gen_start;
  logic        gen_kind;
  logic        gen_done;
  logic [47:0] dst_mac;
  logic        arp_resolved;
  logic [15:0] ipv4_id;
  logic [23:0] full_ipv4;

  // Handshake: gen_start is a one-cycle request (no ready; the generator must
  // accept it), gen_kind/dst_mac/ipv4_id/full_ipv4 are valid with gen_start
  // and held until the next request, and gen_done is a one-cycle pulse on the
  // cycle the frame's terminate word is issued.
  modport master (
    output gen_start, gen_kind, dst_mac, arp_resolved, ipv4_id, full_ipv4,
    input  gen_done
  );

  modport slave (
    input  gen_start, gen_kind, dst_mac, arp_resolved, ipv4_id, full_ipv4,
    output gen_done
  );
endinterface

// File: rtl/tx_frame_sched.sv
// Transmit scheduler: sequences ARP resolution and IPv4 test frames, enforces
// the inter-frame gap, maintains per-frame header fields and publishes
// per-window TX frame and byte counts.
module tx_frame_sched #(
  parameter int unsigned CLK_HZ      = 156250000,
  parameter logic [31:0] ARP_TIMEOUT = 32'd15625000
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    tx_enable,
  input  logic                    tx_req_arp,
  input  logic                    tx_fullroute,
  input  logic [15:0]             tx_frame_len,
  input  logic [31:0]             tx_inter_frame_gap,
  input  logic                    arp_reply_valid,
  input  logic [47:0]             arp_reply_mac,
  tx_frame_sched_if.master        gen,
  output logic [31:0]             tx_pps,
  output logic [31:0]             tx_throughput,
  output logic [2:0]              sched_state
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    REQ_ARP     = 3'd1,
    ARP_BUSY    = 3'd2,
    WAIT_ARPREP = 3'd3,
    SEND        = 3'd4,
    BUSY        = 3'd5,
    GAP         = 3'd6
  } state_t;

  localparam logic [31:0] SEC_RELOAD = 32'(CLK_HZ - 1);
  localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;

  state_t      state_q, state_d;
  logic        gen_start_q, gen_start_d;
  logic        gen_kind_q, gen_kind_d;
  logic [47:0] dst_mac_q, dst_mac_d;
  logic        arp_resolved_q, arp_resolved_d;
  logic [15:0] ipv4_id_q, ipv4_id_d;
  logic [23:0] full_ipv4_q, full_ipv4_d;
  logic [31:0] arp_timer_q, arp_timer_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] sec_cnt_q, sec_cnt_d;
  logic [31:0] win_pkts_q, win_pkts_d;
  logic [31:0] win_bytes_q, win_bytes_d;
  logic [31:0] tx_pps_q, tx_pps_d;
  logic [31:0] tx_thr_q, tx_thr_d;

  // An IPv4 frame completes only when the generator reports done while BUSY;
  // ARP frames and stray pulses do not count.
  logic frame_done;
  assign frame_done = (state_q == BUSY) && gen.gen_done;

  // Next-state logic and per-frame header field updates.
  always_comb begin
    state_d        = state_q;
    arp_timer_d    = arp_timer_q;
    gap_cnt_d      = gap_cnt_q;
    ipv4_id_d      = ipv4_id_q;
    full_ipv4_d    = full_ipv4_q;
    dst_mac_d      = dst_mac_q;
    arp_resolved_d = arp_resolved_q;
    gen_kind_d     = gen_kind_q;

    case (state_q)
      IDLE: begin
        if (tx_enable && tx_req_arp && !arp_resolved_q) begin
          state_d = REQ_ARP;
        end else if (tx_enable) begin
          state_d = SEND;
        end
      end
      REQ_ARP: begin
        state_d = ARP_BUSY;
      end
      ARP_BUSY: begin
        if (gen.gen_done) begin
          arp_timer_d = ARP_TIMEOUT;
          state_d     = WAIT_ARPREP;
        end
      end
      WAIT_ARPREP: begin
        // A reply wins over both the timeout and a dropped enable.
        if (arp_reply_valid) begin
          dst_mac_d      = arp_reply_mac;
          arp_resolved_d = 1'b1;
          state_d        = tx_enable ? SEND : IDLE;
        end else if (arp_timer_q == 32'd0) begin
          state_d = REQ_ARP;
        end else if (!tx_enable) begin
          state_d = IDLE;
        end else begin
          arp_timer_d = arp_timer_q - 32'd1;
        end
      end
      SEND: begin
        state_d = BUSY;
      end
      BUSY: begin
        if (gen.gen_done) begin
          gap_cnt_d = tx_inter_frame_gap;
          ipv4_id_d = ipv4_id_q + 16'd1;
          if (tx_fullroute) begin
            full_ipv4_d = full_ipv4_q + 24'd1;
          end
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == 32'd0) begin
          state_d = tx_enable ? SEND : IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Without ARP the generator always sends to broadcast.
    if (!tx_req_arp) begin
      dst_mac_d      = BCAST_MAC;
      arp_resolved_d = 1'b0;
    end

    // The request flop mirrors the state being entered so gen_start is high
    // exactly while the FSM sits in SEND or REQ_ARP.
    gen_start_d = (state_d == SEND) || (state_d == REQ_ARP);
    if (state_d == SEND) begin
      gen_kind_d = 1'b1;
    end else if (state_d == REQ_ARP) begin
      gen_kind_d = 1'b0;
    end
  end

  // Statistics window: a CLK_HZ-cycle down-counter snapshots the frame and
  // byte counters; a frame finishing on the tick cycle opens the new window.
  always_comb begin
    sec_cnt_d   = sec_cnt_q - 32'd1;
    win_pkts_d  = win_pkts_q;
    win_bytes_d = win_bytes_q;
    tx_pps_d    = tx_pps_q;
    tx_thr_d    = tx_thr_q;

    if (sec_cnt_q == 32'd0) begin
      sec_cnt_d   = SEC_RELOAD;
      tx_pps_d    = win_pkts_q;
      tx_thr_d    = win_bytes_q;
      win_pkts_d  = frame_done ? 32'd1 : 32'd0;
      win_bytes_d = frame_done ? 32'(tx_frame_len) : 32'd0;
    end else if (frame_done) begin
      win_pkts_d  = win_pkts_q + 32'd1;
      win_bytes_d = win_bytes_q + 32'(tx_frame_len);
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs, timers and statistics counters.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gen_start_q    <= 1'b0;
      gen_kind_q     <= 1'b0;
      dst_mac_q      <= BCAST_MAC;
      arp_resolved_q <= 1'b0;
      ipv4_id_q      <= 16'd0;
      full_ipv4_q    <= 24'd0;
      arp_timer_q    <= 32'd0;
      gap_cnt_q      <= 32'd0;
      sec_cnt_q      <= SEC_RELOAD;
      win_pkts_q     <= 32'd0;
      win_bytes_q    <= 32'd0;
      tx_pps_q       <= 32'd0;
      tx_thr_q       <= 32'd0;
    end else begin
      gen_start_q    <= gen_start_d;
      gen_kind_q     <= gen_kind_d;
      dst_mac_q      <= dst_mac_d;
      arp_resolved_q <= arp_resolved_d;
      ipv4_id_q      <= ipv4_id_d;
      full_ipv4_q    <= full_ipv4_d;
      arp_timer_q    <= arp_timer_d;
      gap_cnt_q      <= gap_cnt_d;
      sec_cnt_q      <= sec_cnt_d;
      win_pkts_q     <= win_pkts_d;
      win_bytes_q    <= win_bytes_d;
      tx_pps_q       <= tx_pps_d;
      tx_thr_q       <= tx_thr_d;
    end
  end

  assign gen.gen_start    = gen_start_q;
  assign gen.gen_kind     = gen_kind_q;
  assign gen.dst_mac      = dst_mac_q;
  assign gen.arp_resolved = arp_resolved_q;
  assign gen.ipv4_id      = ipv4_id_q;
  assign gen.full_ipv4    = full_ipv4_q;
  assign tx_pps           = tx_pps_q;
  assign tx_throughput    = tx_thr_q;
  assign sched_state      = state_q;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Bench for tx_frame_sched: a generator responder, a scoreboard of expected
// frame starts (time, kind and header fields) and a per-window statistics
// model built from the completion times of IPv4 frames.
module tb_tx_frame_sched;
  localparam int          CLK_HZ  = 1000;
  localparam logic [31:0] ARP_TO  = 32'd100;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] GW_MAC  = 48'h0011_2233_4455;
  localparam logic [47:0] BAD_MAC = 48'hDEAD_BEEF_0001;
  localparam int          NBKT    = 16;

  typedef struct packed {
    logic        kind;
    logic [47:0] mac;
    logic [15:0] id;
    logic [23:0] full;
    logic [31:0] cyc;
  } exp_t;

  // clock / reset block
  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  int unsigned cyc;
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  logic        tx_enable, tx_req_arp, tx_fullroute;
  logic [15:0] tx_frame_len;
  logic [31:0] tx_inter_frame_gap;
  logic        arp_reply_valid;
  logic [47:0] arp_reply_mac;
  logic [31:0] tx_pps, tx_throughput;
  logic [2:0]  sched_state;
  logic        resp_done, spur_done;

  tx_frame_sched_if gen();
  assign gen.gen_done = resp_done | spur_done;

  tx_frame_sched #(.CLK_HZ(CLK_HZ), .ARP_TIMEOUT(ARP_TO)) dut (
    .sys_clk            (sys_clk),
    .sys_rst            (sys_rst),
    .tx_enable          (tx_enable),
    .tx_req_arp         (tx_req_arp),
    .tx_fullroute       (tx_fullroute),
    .tx_frame_len       (tx_frame_len),
    .tx_inter_frame_gap (tx_inter_frame_gap),
    .arp_reply_valid    (arp_reply_valid),
    .arp_reply_mac      (arp_reply_mac),
    .gen                (gen),
    .tx_pps             (tx_pps),
    .tx_throughput      (tx_throughput),
    .sched_state        (sched_state)
  );

  // scoreboard state
  exp_t        exp_q[$];
  int          busy_q[$];
  int          checks = 0;
  int          errors = 0;
  int          starts_seen = 0;
  int          arp_done_cnt = 0;
  int unsigned arp_done_p = 0;
  logic        stats_en = 1'b0;
  int unsigned bkt_pps[NBKT];
  logic [31:0] bkt_bytes[NBKT];
  logic [15:0] exp_id = 16'd0;
  logic [23:0] exp_full = 24'd0;
  logic [47:0] exp_mac = BCAST;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected IPv4 starts: each frame occupies SEND, its busy time and gap+1.
  task automatic plan_ipv4(input int unsigned first, input int n, input int gap,
                           input int bmin, input int bmax, input logic fr);
    int unsigned t;
    t = first;
    for (int k = 0; k < n; k++) begin
      int   b;
      exp_t e;
      b = $urandom_range(bmax, bmin);
      e.kind = 1'b1; e.mac = exp_mac; e.id = exp_id; e.full = exp_full; e.cyc = 32'(t);
      exp_q.push_back(e);
      busy_q.push_back(b);
      exp_id = exp_id + 16'd1;
      if (fr) exp_full = exp_full + 24'd1;
      t = t + 1 + b + gap + 1;
    end
  endtask

  // Expected ARP requests: retries are spaced by timeout + busy + 2.
  task automatic plan_arp(input int unsigned first, input int n, input int b);
    int unsigned t;
    t = first;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.kind = 1'b0; e.mac = exp_mac; e.id = exp_id; e.full = exp_full; e.cyc = 32'(t);
      exp_q.push_back(e);
      busy_q.push_back(b);
      t = t + ARP_TO + b + 2;
    end
  endtask

  task automatic wait_starts(input int tgt, input int lim);
    int g;
    g = 0;
    while (starts_seen < tgt && g < lim) begin
      @(posedge sys_clk);
      g++;
    end
    check("start_count", 64'(starts_seen), 64'(tgt));
    @(negedge sys_clk);
  endtask

  task automatic wait_idle(input int lim);
    int g;
    g = 0;
    while (sched_state != 3'd0 && g < lim) begin
      @(posedge sys_clk);
      g++;
    end
    check("return_idle", 64'(sched_state), 64'd0);
    @(negedge sys_clk);
  endtask

  task automatic check_reset_values();
    check("rst_gen_start", 64'(gen.gen_start), 64'd0);
    check("rst_gen_kind", 64'(gen.gen_kind), 64'd0);
    check("rst_dst_mac", 64'(gen.dst_mac), 64'(BCAST));
    check("rst_arp_resolved", 64'(gen.arp_resolved), 64'd0);
    check("rst_ipv4_id", 64'(gen.ipv4_id), 64'd0);
    check("rst_full_ipv4", 64'(gen.full_ipv4), 64'd0);
    check("rst_tx_pps", 64'(tx_pps), 64'd0);
    check("rst_tx_throughput", 64'(tx_throughput), 64'd0);
    check("rst_sched_state", 64'(sched_state), 64'd0);
  endtask

  task automatic run_ipv4(input int n, input int gap, input int bmin, input int bmax,
                          input logic fr, input logic [15:0] len);
    int tgt;
    tx_inter_frame_gap = 32'(gap);
    tx_fullroute       = fr;
    tx_frame_len       = len;
    @(negedge sys_clk);
    tgt = starts_seen + n;
    plan_ipv4(cyc + 1, n, gap, bmin, bmax, fr);
    tx_enable = 1'b1;
    wait_starts(tgt, n * (gap + bmax + 4) + 20);
    tx_enable = 1'b0;
    wait_idle(gap + bmax + 40);
    check("run_ipv4_id", 64'(gen.ipv4_id), 64'(exp_id));
    check("run_full_ipv4", 64'(gen.full_ipv4), 64'(exp_full));
    check("run_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // generator responder: answers each request with gen_done after its busy time
  initial begin
    for (int i = 0; i < NBKT; i++) begin
      bkt_pps[i]   = 0;
      bkt_bytes[i] = 32'd0;
    end
    resp_done = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && gen.gen_start) begin
        int          b;
        logic        k;
        int unsigned p;
        k = gen.gen_kind;
        b = (busy_q.size() != 0) ? busy_q.pop_front() : 3;
        repeat (b) @(negedge sys_clk);
        resp_done = 1'b1;
        p = cyc + 1;
        if (k && stats_en && (p / CLK_HZ) < NBKT) begin
          bkt_pps[p / CLK_HZ]   = bkt_pps[p / CLK_HZ] + 1;
          bkt_bytes[p / CLK_HZ] = bkt_bytes[p / CLK_HZ] + 32'(tx_frame_len);
        end
        if (!k) begin
          arp_done_p   = p;
          arp_done_cnt = arp_done_cnt + 1;
        end
        @(negedge sys_clk);
        resp_done = 1'b0;
      end
    end
  end

  // monitor: pops the scoreboard on every request and checks window snapshots
  initial begin
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && gen.gen_start) begin
        starts_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got gen_start kind %0d at cycle %0d, expected none",
                   gen.gen_kind, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("start_cycle", 64'(cyc), 64'(e.cyc));
          check("gen_kind", 64'(gen.gen_kind), 64'(e.kind));
          check("dst_mac", 64'(gen.dst_mac), 64'(e.mac));
          check("ipv4_id", 64'(gen.ipv4_id), 64'(e.id));
          check("full_ipv4", 64'(gen.full_ipv4), 64'(e.full));
        end
      end
      if (!sys_rst && stats_en && cyc != 0 && (cyc % CLK_HZ) == 0 && (cyc / CLK_HZ) <= NBKT) begin
        check("tx_pps", 64'(tx_pps), 64'(bkt_pps[cyc / CLK_HZ - 1]));
        check("tx_throughput", 64'(tx_throughput), 64'(bkt_bytes[cyc / CLK_HZ - 1]));
      end
    end
  end

  // driver / main sequence
  initial begin
    int tgt;
    int g;
    int base;
    sys_rst            = 1'b1;
    tx_enable          = 1'b0;
    tx_req_arp         = 1'b0;
    tx_fullroute       = 1'b0;
    tx_frame_len       = 16'd64;
    tx_inter_frame_gap = 32'd0;
    arp_reply_valid    = 1'b0;
    arp_reply_mac      = 48'd0;
    spur_done          = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset_values();
    sys_rst  = 1'b0;
    stats_en = 1'b1;

    // broadcast IPv4 at a fixed 21-cycle cadence
    run_ipv4(6, 10, 9, 9, 1'b0, 16'd64);

    // randomized broadcast runs
    for (int r = 0; r < 3; r++) begin
      run_ipv4($urandom_range(9, 4), $urandom_range(15, 0), 1, 12,
               1'($urandom_range(1, 0)), 16'($urandom_range(1518, 64)));
    end

    // stray gen_done and ARP reply while idle must change nothing
    tx_req_arp = 1'b1;
    @(negedge sys_clk);
    spur_done = 1'b1; arp_reply_valid = 1'b1; arp_reply_mac = BAD_MAC;
    @(negedge sys_clk);
    spur_done = 1'b0; arp_reply_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("idle_ipv4_id", 64'(gen.ipv4_id), 64'(exp_id));
    check("idle_dst_mac", 64'(gen.dst_mac), 64'(BCAST));
    check("idle_arp_resolved", 64'(gen.arp_resolved), 64'd0);
    check("idle_state", 64'(sched_state), 64'd0);

    // ARP resolution: one request, bogus replies while requesting, real reply
    // 50 cycles after the ARP frame completes
    tx_inter_frame_gap = 32'($urandom_range(8, 0));
    tx_fullroute = 1'b1;
    tx_frame_len = 16'd128;
    exp_mac = BCAST;
    @(negedge sys_clk);
    base = arp_done_cnt;
    plan_arp(cyc + 1, 1, 4);
    tx_enable = 1'b1;
    @(negedge sys_clk);
    arp_reply_valid = 1'b1; arp_reply_mac = BAD_MAC;
    repeat (2) @(negedge sys_clk);
    arp_reply_valid = 1'b0;
    g = 0;
    while (arp_done_cnt == base && g < 50) begin
      @(negedge sys_clk);
      g++;
    end
    check("arp_frame_done", 64'(arp_done_cnt), 64'(base + 1));
    g = 0;
    while (cyc < arp_done_p + 49 && g < 100) begin
      @(negedge sys_clk);
      g++;
    end
    exp_mac = GW_MAC;
    tgt = starts_seen + 4;
    plan_ipv4(cyc + 1, 4, int'(tx_inter_frame_gap), 1, 8, 1'b1);
    arp_reply_valid = 1'b1; arp_reply_mac = GW_MAC;
    @(negedge sys_clk);
    arp_reply_valid = 1'b0;
    wait_starts(tgt, 200);
    tx_enable = 1'b0;
    wait_idle(60);
    check("arp_resolved_set", 64'(gen.arp_resolved), 64'd1);
    check("arp_learned_mac", 64'(gen.dst_mac), 64'(GW_MAC));
    check("arp_queue_drained", 64'(exp_q.size()), 64'd0);

    // dropping the ARP request forces broadcast again
    tx_req_arp = 1'b0;
    repeat (2) @(negedge sys_clk);
    exp_mac = BCAST;
    check("noarp_dst_mac", 64'(gen.dst_mac), 64'(BCAST));
    check("noarp_resolved", 64'(gen.arp_resolved), 64'd0);

    // ARP timeout: requests repeat with no reply
    tx_req_arp = 1'b1;
    @(negedge sys_clk);
    tgt = starts_seen + 3;
    plan_arp(cyc + 1, 3, 3);
    tx_enable = 1'b1;
    @(negedge sys_clk);
    arp_reply_valid = 1'b1; arp_reply_mac = BAD_MAC;
    @(negedge sys_clk);
    arp_reply_valid = 1'b0;
    wait_starts(tgt, 400);
    tx_enable = 1'b0;
    wait_idle(200);
    check("timeout_resolved", 64'(gen.arp_resolved), 64'd0);
    check("timeout_dst_mac", 64'(gen.dst_mac), 64'(BCAST));
    check("timeout_queue_drained", 64'(exp_q.size()), 64'd0);
    tx_req_arp = 1'b0;
    repeat (2) @(negedge sys_clk);

    // back-to-back frames with no gap and fixed busy time
    run_ipv4(250, 0, 3, 3, 1'b1, 16'd64);

    // a frame whose gen_done lands exactly on the window tick
    while ((cyc % CLK_HZ) != 992) @(negedge sys_clk);
    run_ipv4(1, 2, 5, 5, 1'b0, 16'd100);
    repeat (1010) @(negedge sys_clk);

    // asynchronous reset in the middle of a gap
    tx_inter_frame_gap = 32'd40;
    tx_frame_len = 16'd64;
    @(negedge sys_clk);
    tgt = starts_seen + 1;
    plan_ipv4(cyc + 1, 1, 40, 3, 3, 1'b0);
    tx_enable = 1'b1;
    wait_starts(tgt, 60);
    g = 0;
    while (sched_state != 3'd6 && g < 20) begin
      @(posedge sys_clk);
      g++;
    end
    check("reached_gap", 64'(sched_state), 64'd6);
    check("final_queue_drained", 64'(exp_q.size()), 64'd0);
    @(negedge sys_clk);
    stats_en = 1'b0;
    #2 sys_rst = 1'b1;
    #1 check_reset_values();
    tx_enable = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
